// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, state encoding,
// ALU operation codes, PC source selects and the decoded instruction class.
package cu_pkg;

  localparam logic [5:0] OPC_ADD  = 6'b000000;
  localparam logic [5:0] OPC_SUB  = 6'b000010;
  localparam logic [5:0] OPC_SLT  = 6'b000100;
  localparam logic [5:0] OPC_AND  = 6'b010001;
  localparam logic [5:0] OPC_OR   = 6'b010010;
  localparam logic [5:0] OPC_XOR  = 6'b010100;
  localparam logic [5:0] OPC_SW   = 6'b100110;
  localparam logic [5:0] OPC_LW   = 6'b100111;
  localparam logic [5:0] OPC_BEQ  = 6'b110000;
  localparam logic [5:0] OPC_JMP  = 6'b110010;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EXE_R = 3'd2,
    S_EXE_M = 3'd3,
    S_EXE_B = 3'd4,
    S_MEM   = 3'd5,
    S_WB    = 3'd6,
    S_HALT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_R, CL_MEM, CL_BR, CL_JMP, CL_HALT, CL_ILL
  } op_class_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: instruction class, ALU function and LW flag.
// Opcodes wider than 6 bits must carry zeros in the upper bits to decode.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op,
  output op_class_e          op_class,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_lw
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    op_class = CL_ILL;
    alu_op   = '0;
    is_lw    = 1'b0;
    case (op)
      OP_W'(OPC_ADD):  begin op_class = CL_R;   alu_op = ALUOP_W'(ALU_ADD); end
      OP_W'(OPC_SUB):  begin op_class = CL_R;   alu_op = ALUOP_W'(ALU_SUB); end
      OP_W'(OPC_SLT):  begin op_class = CL_R;   alu_op = ALUOP_W'(ALU_SLT); end
      OP_W'(OPC_AND):  begin op_class = CL_R;   alu_op = ALUOP_W'(ALU_AND); end
      OP_W'(OPC_OR):   begin op_class = CL_R;   alu_op = ALUOP_W'(ALU_OR);  end
      OP_W'(OPC_XOR):  begin op_class = CL_R;   alu_op = ALUOP_W'(ALU_XOR); end
      OP_W'(OPC_SW):   begin op_class = CL_MEM; alu_op = ALUOP_W'(ALU_ADD); end
      OP_W'(OPC_LW):   begin op_class = CL_MEM; alu_op = ALUOP_W'(ALU_ADD); is_lw = 1'b1; end
      OP_W'(OPC_BEQ):  begin op_class = CL_BR;  alu_op = ALUOP_W'(ALU_SUB); end
      OP_W'(OPC_JMP):  begin op_class = CL_JMP; alu_op = ALUOP_W'(ALU_SUB); end
      OP_W'(OPC_HALT): op_class = CL_HALT;
      default:         op_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) driving per-state datapath enables.
// Define CU_ILLEGAL_TRAP_EN to trap unknown opcodes into S_HALT; otherwise they retire as NOPs.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    operation,
  input  logic               zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               RegWre,
  output logic               RegOut,
  output logic               DataMemRW,
  output logic               ExtSel,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               halted,
  output logic               illegal
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q;
  logic [CNT_W-1:0]   lat_cnt;

  op_class_e          dis_class, q_class;
  logic [ALUOP_W-1:0] dis_alu_op, q_alu_op;
  logic               dis_is_lw, q_is_lw;
  logic               dis_unused;

  // Dispatch decodes the live opcode in ID; outputs decode the latched copy.
  cu_decoder #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_dec_dispatch (
    .op(operation), .op_class(dis_class), .alu_op(dis_alu_op), .is_lw(dis_is_lw)
  );

  cu_decoder #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_dec_op_q (
    .op(op_q), .op_class(q_class), .alu_op(q_alu_op), .is_lw(q_is_lw)
  );

  assign dis_unused = ^{dis_alu_op, dis_is_lw};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      lat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= operation;
      if (state_q == S_EXE_M)      lat_cnt <= '0;
      else if (state_q == S_MEM)   lat_cnt <= lat_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    RegWre    = 1'b0;
    RegOut    = 1'b0;
    DataMemRW = 1'b0;
    PCSrc     = PCSRC_SEQ;
    ALUOp     = '0;
    halted    = 1'b0;
    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (dis_class)
          CL_HALT: state_d = S_HALT;
          CL_JMP: begin
            PCWre   = 1'b1;
            PCSrc   = PCSRC_JMP;
            state_d = S_IF;
          end
          CL_BR:   state_d = S_EXE_B;
          CL_MEM:  state_d = S_EXE_M;
          CL_R:    state_d = S_EXE_R;
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            PCWre   = 1'b1;
            state_d = S_IF;
`endif
          end
        endcase
      end
      S_EXE_R: begin
        ALUOp   = q_alu_op;
        state_d = S_WB;
      end
      S_EXE_M: begin
        ALUSrcB = 1'b1;
        ALUOp   = ALUOP_W'(ALU_ADD);
        state_d = S_MEM;
      end
      S_EXE_B: begin
        ALUOp   = ALUOP_W'(ALU_SUB);
        PCWre   = 1'b1;
        PCSrc   = zero ? PCSRC_BR : PCSRC_SEQ;
        state_d = S_IF;
      end
      S_MEM: begin
        ALUSrcB   = 1'b1;
        DataMemRW = (q_class == CL_MEM) && !q_is_lw;
        if (lat_cnt == LAT_LAST) begin
          if (q_is_lw) begin
            state_d = S_WB;
          end else begin
            PCWre   = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        RegWre   = 1'b1;
        PCWre    = 1'b1;
        ALUM2Reg = q_is_lw;
        RegOut   = !q_is_lw;
        state_d  = S_IF;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       illegal_q <= 1'b0;
    else if (state_q == S_ID && dis_class == CL_ILL) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign InsMemRW   = 1'b0;
  assign ExtSel     = 1'b1;
  assign instr_done = PCWre;
  assign state      = state_q;

endmodule
